axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
//  Arbitrates the AXI read channel (AR/R) between the instruction cache and the data cache.
//  Sits between i_cache/d_cache read ports and the top-level AXI master read channel.
//  Allows one outstanding burst at a time, routes R beats to the granted cache and
//  checks beat count against arlen.
// PARAMETERS
//  AW      32  address width
//  DW      32  data width
//  I_ID    0   arid driven for i_cache bursts
//  D_ID    1   arid driven for d_cache bursts
// PORTS
//  clk        in   1    clock
//  rst        in   1    synchronous reset, active high
//  i_araddr   in   AW   i_cache burst address
//  i_arlen    in   8    i_cache burst length-1
//  i_arsize   in   3    i_cache beat size
//  i_arvalid  in   1    i_cache read request
//  i_arready  out  1    i_cache request accepted
//  i_rdata    out  DW   read data to i_cache
//  i_rlast    out  1    last beat to i_cache
//  i_rvalid   out  1    beat valid to i_cache
//  i_rready   in   1    i_cache can accept beat
//  d_araddr, d_arlen, d_arsize, d_arvalid, d_arready,
//  d_rdata, d_rlast, d_rvalid, d_rready: same widths/directions as the i_* ports, for d_cache
//  arid       out  4    AXI AR id
//  araddr     out  AW   AXI AR address
//  arlen      out  8    AXI AR length
//  arsize     out  3    AXI AR size
//  arburst    out  2    constant 2'b01 (INCR)
//  arvalid    out  1    AXI AR valid
//  arready    in   1    AXI AR ready
//  rid        in   4    AXI R id (ignored for routing; one outstanding burst)
//  rdata      in   DW   AXI R data
//  rresp      in   2    AXI R response
//  rlast      in   1    AXI R last
//  rvalid     in   1    AXI R valid
//  rready     out  1    AXI R ready
//  rd_err     out  1    sticky: rresp!=OKAY, or rlast/beat-count mismatch
// BEHAVIOUR
//  State machine (IDLE, ADDR, DATA):
//  - IDLE: pick grant when any *_arvalid; D has fixed priority over I.
//    Latch addr, len, size and id; go to ADDR next cycle.
//  - ADDR: arvalid=1 with the latched fields, held stable until arready.
//    On arready: pulse the granted cache's *_arready for that same cycle, clear beat count, go to DATA.
//  - DATA: rready = granted cache's *_rready. Other cache sees rvalid=0, rlast=0.
//    On every rvalid&&rready: increment 8-bit beat count.
//    On rvalid&&rready&&rlast: go to IDLE. A new grant can be taken on the following cycle.
//  Latency: request to arvalid is 1 cycle; the R path is combinational (rdata passes through unregistered).
//  Errors:
//  - rlast with count!=arlen, or count==arlen beat without rlast -> set rd_err.
//    The FSM still ends the burst on rlast.
//  - rresp!=2'b00 on any accepted beat -> set rd_err.
//  - rd_err clears only on rst.
//  Simultaneous I and D requests in IDLE: D wins. I stays pending; its arvalid must stay asserted.
//  Requests arriving during ADDR/DATA wait in IDLE.
//  A requester dropping *_arvalid before its grant: the grant is already latched, so the burst still issues (caches must not withdraw requests).
//  Reset mid-burst: FSM -> IDLE. Outputs cleared; any AXI burst in flight is abandoned.
//  Reset values: arvalid=0, rready=0, *_arready=0, *_rvalid=0, *_rlast=0, rd_err=0, arid=0,
//  araddr=0, arlen=0, arsize=0, state=IDLE.
// CONFIGURATION
//  AXI_RD_RR_EN defined: round-robin between I and D. The last-granted requester loses ties;
//  the priority flag updates at ADDR->DATA.
//  AXI_RD_RR_EN undefined: fixed D-over-I priority as above.
// STRUCTURE
//  Package axi_rd_pkg: typedef enum rd_state_t {IDLE, ADDR, DATA}; typedef struct rd_req_t
//  {addr, len, size, id}; localparams RESP_OKAY=2'b00, BURST_INCR=2'b01.
//  One sub-module: rd_grant_sel, the combinational plus priority-flag grant logic.
//  It is the only place AXI_RD_RR_EN is tested.
// TESTING
//  1 D alone, araddr=0x1000, arlen=7, arready after 2 cycles -> arid=1, d_arready one pulse,
//    8 beats to d_cache, last with d_rlast, FSM IDLE, rd_err=0.
//  2 I and D assert in the same cycle -> D burst first; I burst (arid=0) issues after D rlast.
//    With AXI_RD_RR_EN and a repeated tie, the order alternates I/D.
//  3 d_rready low for 3 cycles mid-burst -> rready low, no beat lost, beat count unchanged.
//  4 arlen=3 but rlast on beat 2 -> rd_err=1 and stays 1; FSM returns to IDLE.
//    Next burst proceeds normally.
//  5 rresp=2'b10 on beat 0 -> rd_err=1.
//  6 rst=1 during DATA beat 4 of 8 -> next cycle arvalid=0, rready=0, state=IDLE, rd_err=0.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared types and constants for the AXI read arbiter
package axi_rd_pkg;

    localparam int RD_AW = 32;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [RD_AW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [3:0]       id;
    } rd_req_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - cache read port and AXI read channel interfaces
interface cache_rd_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    // master = cache side, slave = arbiter side
    modport master (output araddr, arlen, arsize, arvalid, rready,
                    input  arready, rdata, rlast, rvalid);
    modport slave  (input  araddr, arlen, arsize, arvalid, rready,
                    output arready, rdata, rlast, rvalid);
endinterface

interface axi_rd_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [3:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [3:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport master (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    input  arready, rid, rdata, rresp, rlast, rvalid);
    modport slave  (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
                    output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_rd_arbiter_grant_sel.sv
// rtl/axi_rd_arbiter_grant_sel.sv - I/D grant selection; AXI_RD_RR_EN selects round-robin
module rd_grant_sel (
    input  logic clk,
    input  logic rst,
    input  logic icache_req,
    input  logic dcache_req,
    input  logic upd,
    input  logic cur_dcache,
    output logic grant_valid,
    output logic grant_d
);

`ifdef AXI_RD_RR_EN
    logic last_d_q;

    // The requester granted last loses a tie; the flag moves once the address is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (upd) begin
            last_d_q <= cur_dcache;
        end
    end

    assign grant_d = dcache_req && (!icache_req || !last_d_q);
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, upd, cur_dcache};

    assign grant_d = dcache_req;
`endif

    assign grant_valid = icache_req | dcache_req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - one-outstanding-burst AXI read arbiter between i_cache and d_cache
// Optional round-robin grant when AXI_RD_RR_EN is defined (fixed D-over-I otherwise).
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int         AW   = RD_AW,
    parameter int         DW   = 32,
    parameter logic [3:0] I_ID = 4'd0,
    parameter logic [3:0] D_ID = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    cache_rd_if.slave  icache,
    cache_rd_if.slave  dcache,
    axi_rd_if.master   axi,
    output logic       rd_err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ADDR = ADDR;
    localparam logic [1:0] ST_DATA = DATA;

    logic [1:0] state_q;
    rd_req_t    req_q;
    rd_req_t    sel_req;
    logic       grant_d_q;
    logic [7:0] beat_q;
    logic       grant_valid;
    logic       grant_d;
    logic       in_data;
    logic       ar_fire;
    logic       beat_acc;
    logic       unused_ok;

    assign unused_ok = ^axi.rid;

    rd_grant_sel u_grant_sel (
        .clk         (clk),
        .rst         (rst),
        .icache_req  (icache.arvalid),
        .dcache_req  (dcache.arvalid),
        .upd         (ar_fire),
        .cur_dcache  (grant_d_q),
        .grant_valid (grant_valid),
        .grant_d     (grant_d)
    );

    always_comb begin
        sel_req = '0;
        if (grant_d) begin
            sel_req.addr = RD_AW'(dcache.araddr);
            sel_req.len  = dcache.arlen;
            sel_req.size = dcache.arsize;
            sel_req.id   = D_ID;
        end else begin
            sel_req.addr = RD_AW'(icache.araddr);
            sel_req.len  = icache.arlen;
            sel_req.size = icache.arsize;
            sel_req.id   = I_ID;
        end
    end

    assign in_data  = (state_q == ST_DATA);
    assign ar_fire  = (state_q == ST_ADDR) && axi.arready;
    assign beat_acc = in_data && axi.rvalid && axi.rready;

    // The burst always ends on rlast, even when the beat count disagrees with arlen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            grant_d_q <= 1'b0;
            beat_q    <= 8'd0;
            rd_err    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        req_q     <= sel_req;
                        grant_d_q <= grant_d;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axi.arready) begin
                        beat_q  <= 8'd0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        beat_q <= beat_q + 8'd1;
                        if ((axi.rresp != RESP_OKAY) ||
                            (axi.rlast != (beat_q == req_q.len))) begin
                            rd_err <= 1'b1;
                        end
                        if (axi.rlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axi.arvalid = (state_q == ST_ADDR);
    assign axi.arid    = req_q.id;
    assign axi.araddr  = AW'(req_q.addr);
    assign axi.arlen   = req_q.len;
    assign axi.arsize  = req_q.size;
    assign axi.arburst = BURST_INCR;
    assign axi.rready  = in_data && (grant_d_q ? dcache.rready : icache.rready);

    assign icache.arready = ar_fire && !grant_d_q;
    assign dcache.arready = ar_fire && grant_d_q;

    // R data passes through unregistered; only valid/last are steered.
    assign icache.rdata  = DW'(axi.rdata);
    assign dcache.rdata  = DW'(axi.rdata);
    assign icache.rvalid = in_data && !grant_d_q && axi.rvalid;
    assign icache.rlast  = in_data && !grant_d_q && axi.rlast;
    assign dcache.rvalid = in_data && grant_d_q && axi.rvalid;
    assign dcache.rlast  = in_data && grant_d_q && axi.rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;
    import axi_rd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rd_err;
    int   total = 0;
    int   passed = 0;
    logic last_d_tb;

    cache_rd_if #(.AW(32), .DW(32)) ic ();
    cache_rd_if #(.AW(32), .DW(32)) dc ();
    axi_rd_if   #(.AW(32), .DW(32)) ax ();

    axi_rd_arbiter #(.AW(32), .DW(32), .I_ID(4'd0), .D_ID(4'd1)) dut (
        .clk    (clk),
        .rst    (rst),
        .icache (ic),
        .dcache (dc),
        .axi    (ax),
        .rd_err (rd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_inputs();
        ic.araddr = '0; ic.arlen = '0; ic.arsize = '0; ic.arvalid = 1'b0; ic.rready = 1'b1;
        dc.araddr = '0; dc.arlen = '0; dc.arsize = '0; dc.arvalid = 1'b0; dc.rready = 1'b1;
        ax.arready = 1'b0; ax.rid = '0; ax.rdata = '0; ax.rresp = 2'b00;
        ax.rlast = 1'b0; ax.rvalid = 1'b0;
    endtask

    task automatic ar_phase(input int wait_cyc, output logic [3:0] id, output logic [31:0] addr,
                            output logic [7:0] len, output int pi, output int pd, output int bad);
        int n;
        pi = 0; pd = 0; bad = 0; n = 0; id = '0; addr = '0; len = '0;
        while (ax.arvalid !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (ax.arvalid !== 1'b1) begin
            bad = 1;
            return;
        end
        id = ax.arid; addr = ax.araddr; len = ax.arlen;
        for (int k = 0; k < wait_cyc; k++) begin
            pi += int'(ic.arready); pd += int'(dc.arready);
            @(negedge clk); #1;
            if (ax.arvalid !== 1'b1 || ax.arid !== id || ax.araddr !== addr || ax.arlen !== len) bad++;
        end
        ax.arready = 1'b1; #1;
        pi += int'(ic.arready); pd += int'(dc.arready);
        @(negedge clk);
        ax.arready = 1'b0; #1;
        pi += int'(ic.arready); pd += int'(dc.arready);
    endtask

    task automatic serve_r(input int nbeats, input int last_at, input int bad_at, input int stall_at,
                           input logic to_d, output int got, output int lastc, output int leak,
                           output int stall_bad);
        logic [31:0] exp_data;
        got = 0; lastc = 0; leak = 0; stall_bad = 0;
        for (int b = 0; b < nbeats; b++) begin
            exp_data  = 32'hA500_0000 + b;
            ax.rvalid = 1'b1;
            ax.rdata  = exp_data;
            ax.rlast  = (b == last_at);
            ax.rresp  = (b == bad_at) ? 2'b10 : 2'b00;
            if (b == stall_at) begin
                if (to_d) dc.rready = 1'b0; else ic.rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    if (ax.rready !== 1'b0) stall_bad++;
                    @(negedge clk); #1;
                    if (dut.beat_q !== 8'(b)) stall_bad++;
                end
                dc.rready = 1'b1; ic.rready = 1'b1;
            end
            #1;
            if (to_d) begin
                if (dc.rvalid === 1'b1 && dc.rdata === exp_data) got++;
                if (dc.rlast === 1'b1) lastc++;
                if (ic.rvalid !== 1'b0 || ic.rlast !== 1'b0) leak++;
            end else begin
                if (ic.rvalid === 1'b1 && ic.rdata === exp_data) got++;
                if (ic.rlast === 1'b1) lastc++;
                if (dc.rvalid !== 1'b0 || dc.rlast !== 1'b0) leak++;
            end
            if (ax.rready !== 1'b1) stall_bad++;
            @(negedge clk);
        end
        ax.rvalid = 1'b0; ax.rlast = 1'b0; ax.rresp = 2'b00; #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (ax.arvalid !== 1'b0) $display("FAIL reset_arvalid: got %0b want 0", ax.arvalid); else passed++;
        total++; if (ax.rready !== 1'b0) $display("FAIL reset_rready: got %0b want 0", ax.rready); else passed++;
        total++; if ({ic.arready, dc.arready, ic.rvalid, dc.rvalid, ic.rlast, dc.rlast} !== 6'b0)
            $display("FAIL reset_cache_outs: got %b want 000000",
                     {ic.arready, dc.arready, ic.rvalid, dc.rvalid, ic.rlast, dc.rlast}); else passed++;
        total++; if (rd_err !== 1'b0) $display("FAIL reset_rd_err: got %0b want 0", rd_err); else passed++;
        total++; if ({ax.arid, ax.araddr, ax.arlen, ax.arsize} !== 47'b0)
            $display("FAIL reset_ar_fields: got %0h want 0", {ax.arid, ax.araddr, ax.arlen, ax.arsize}); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL reset_state: got %0d want 0", dut.state_q); else passed++;
        rst = 1'b0;
        last_d_tb = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_d_alone();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        int pi, pd, bad, got, lastc, leak, sb;
        dc.araddr = 32'h1000; dc.arlen = 8'd7; dc.arsize = 3'd2; dc.arvalid = 1'b1; #1;
        total++; if (ax.arvalid !== 1'b0) $display("FAIL d_latency_pre: got %0b want 0", ax.arvalid); else passed++;
        @(negedge clk); #1;
        total++; if (ax.arvalid !== 1'b1) $display("FAIL d_latency_one: got %0b want 1", ax.arvalid); else passed++;
        ar_phase(2, id, addr, len, pi, pd, bad);
        dc.arvalid = 1'b0;
        total++; if (bad !== 0) $display("FAIL d_ar_stable: got %0d want 0", bad); else passed++;
        total++; if (id !== 4'd1) $display("FAIL d_arid: got %0d want 1", id); else passed++;
        total++; if (addr !== 32'h1000) $display("FAIL d_araddr: got %0h want 1000", addr); else passed++;
        total++; if (len !== 8'd7) $display("FAIL d_arlen: got %0d want 7", len); else passed++;
        total++; if (ax.arsize !== 3'd2) $display("FAIL d_arsize: got %0d want 2", ax.arsize); else passed++;
        total++; if (ax.arburst !== 2'b01) $display("FAIL d_arburst: got %0d want 1", ax.arburst); else passed++;
        total++; if (pd !== 1 || pi !== 0) $display("FAIL d_arready_pulse: got d=%0d i=%0d want d=1 i=0", pd, pi); else passed++;
        serve_r(8, 7, -1, -1, 1'b1, got, lastc, leak, sb);
        total++; if (got !== 8) $display("FAIL d_beats: got %0d want 8", got); else passed++;
        total++; if (lastc !== 1) $display("FAIL d_rlast: got %0d want 1", lastc); else passed++;
        total++; if (leak !== 0) $display("FAIL d_leak_to_i: got %0d want 0", leak); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL d_end_state: got %0d want 0", dut.state_q); else passed++;
        total++; if (rd_err !== 1'b0) $display("FAIL d_rd_err: got %0b want 0", rd_err); else passed++;
        last_d_tb = 1'b1;
    endtask

    task automatic test_tie();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        logic [31:0] exp_addr;
        logic first_d, cur_d;
        int pi, pd, bad, got, lastc, leak, sb, nb;
        for (int t = 0; t < 2; t++) begin
            ic.araddr = 32'h2000 + 32'(t * 16); ic.arlen = 8'd3; ic.arvalid = 1'b1;
            dc.araddr = 32'h3000 + 32'(t * 16); dc.arlen = 8'd1; dc.arvalid = 1'b1;
`ifdef AXI_RD_RR_EN
            first_d = !last_d_tb;
`else
            first_d = 1'b1;
`endif
            for (int k = 0; k < 2; k++) begin
                cur_d = (k == 0) ? first_d : !first_d;
                exp_addr = cur_d ? (32'h3000 + 32'(t * 16)) : (32'h2000 + 32'(t * 16));
                ar_phase(0, id, addr, len, pi, pd, bad);
                if (cur_d) dc.arvalid = 1'b0; else ic.arvalid = 1'b0;
                total++; if (bad !== 0) $display("FAIL tie_ar_timeout: got %0d want 0", bad); else passed++;
                total++; if (id !== (cur_d ? 4'd1 : 4'd0)) $display("FAIL tie_order_id: got %0d want %0d", id, cur_d); else passed++;
                total++; if (addr !== exp_addr) $display("FAIL tie_araddr: got %0h want %0h", addr, exp_addr); else passed++;
                total++; if ((cur_d ? pd : pi) !== 1 || (cur_d ? pi : pd) !== 0)
                    $display("FAIL tie_arready_pulse: got d=%0d i=%0d want granted=1 other=0", pd, pi); else passed++;
                nb = cur_d ? 2 : 4;
                serve_r(nb, nb - 1, -1, -1, cur_d, got, lastc, leak, sb);
                total++; if (got !== nb || leak !== 0)
                    $display("FAIL tie_beats: got %0d leak %0d want %0d leak 0", got, leak, nb); else passed++;
                last_d_tb = cur_d;
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        int pi, pd, bad, got, lastc, leak, sb;
        dc.araddr = 32'h4000; dc.arlen = 8'd7; dc.arvalid = 1'b1;
        ar_phase(0, id, addr, len, pi, pd, bad);
        dc.arvalid = 1'b0;
        serve_r(8, 7, -1, 4, 1'b1, got, lastc, leak, sb);
        total++; if (sb !== 0) $display("FAIL stall_rready_count: got %0d want 0", sb); else passed++;
        total++; if (got !== 8 || lastc !== 1) $display("FAIL stall_beats: got %0d/%0d want 8/1", got, lastc); else passed++;
        total++; if (rd_err !== 1'b0) $display("FAIL stall_rd_err: got %0b want 0", rd_err); else passed++;
        last_d_tb = 1'b1;
    endtask

    task automatic test_len_err();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        int pi, pd, bad, got, lastc, leak, sb;
        dc.araddr = 32'h5000; dc.arlen = 8'd3; dc.arvalid = 1'b1;
        ar_phase(0, id, addr, len, pi, pd, bad);
        dc.arvalid = 1'b0;
        serve_r(3, 2, -1, -1, 1'b1, got, lastc, leak, sb);
        total++; if (rd_err !== 1'b1) $display("FAIL len_err_set: got %0b want 1", rd_err); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL len_err_state: got %0d want 0", dut.state_q); else passed++;
        ic.araddr = 32'h6000; ic.arlen = 8'd1; ic.arvalid = 1'b1;
        ar_phase(0, id, addr, len, pi, pd, bad);
        ic.arvalid = 1'b0;
        total++; if (id !== 4'd0 || addr !== 32'h6000) $display("FAIL len_err_next_ar: got id %0d addr %0h want 0 6000", id, addr); else passed++;
        serve_r(2, 1, -1, -1, 1'b0, got, lastc, leak, sb);
        total++; if (got !== 2 || lastc !== 1) $display("FAIL len_err_next_beats: got %0d/%0d want 2/1", got, lastc); else passed++;
        total++; if (rd_err !== 1'b1) $display("FAIL len_err_sticky: got %0b want 1", rd_err); else passed++;
        last_d_tb = 1'b0;
    endtask

    task automatic test_resp_err();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        int pi, pd, bad, got, lastc, leak, sb;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        last_d_tb = 1'b0;
        total++; if (rd_err !== 1'b0) $display("FAIL resp_pre_clear: got %0b want 0", rd_err); else passed++;
        dc.araddr = 32'h7000; dc.arlen = 8'd1; dc.arvalid = 1'b1;
        ar_phase(0, id, addr, len, pi, pd, bad);
        dc.arvalid = 1'b0;
        serve_r(2, 1, 0, -1, 1'b1, got, lastc, leak, sb);
        total++; if (rd_err !== 1'b1) $display("FAIL resp_err_set: got %0b want 1", rd_err); else passed++;
        total++; if (got !== 2) $display("FAIL resp_err_beats: got %0d want 2", got); else passed++;
        last_d_tb = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [3:0] id; logic [31:0] addr; logic [7:0] len;
        int pi, pd, bad, got, lastc, leak, sb;
        dc.araddr = 32'h8000; dc.arlen = 8'd7; dc.arvalid = 1'b1;
        ar_phase(0, id, addr, len, pi, pd, bad);
        dc.arvalid = 1'b0;
        serve_r(4, -1, -1, -1, 1'b1, got, lastc, leak, sb);
        total++; if (got !== 4 || dut.beat_q !== 8'd4) $display("FAIL mid_pre_beats: got %0d cnt %0d want 4 4", got, dut.beat_q); else passed++;
        ax.rvalid = 1'b1; ax.rdata = 32'hA500_0004; rst = 1'b1;
        @(negedge clk); #1;
        total++; if (ax.arvalid !== 1'b0 || ax.rready !== 1'b0)
            $display("FAIL mid_rst_handshake: got arvalid %0b rready %0b want 0 0", ax.arvalid, ax.rready); else passed++;
        total++; if (dut.state_q !== IDLE) $display("FAIL mid_rst_state: got %0d want 0", dut.state_q); else passed++;
        total++; if (rd_err !== 1'b0) $display("FAIL mid_rst_rd_err: got %0b want 0", rd_err); else passed++;
        total++; if (dc.rvalid !== 1'b0) $display("FAIL mid_rst_d_rvalid: got %0b want 0", dc.rvalid); else passed++;
        rst = 1'b0; ax.rvalid = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_d_alone();
        test_tie();
        test_stall();
        test_len_err();
        test_resp_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
